// File: rtl/cpu_io_target_if.sv
// Bus bundle between the embedded CPU I/O path / event consumer and cpu_io_target.
// slave = target view, master = CPU + consumer view.
`timescale 1ns/1ps
interface cpu_io_target_if #(parameter int NREG = 8);
  logic [15:0]        op;
  logic [31:0]        tos;
  logic               rdReg;
  logic               wrReg;
  logic               wrReg2;
  logic               wrEvt;
  logic               wrEvt2;
  logic               wrEvtL;
  logic [15:0]        par;
  logic [NREG*32-1:0] regs_a;
  logic [NREG*32-1:0] regs_b;
  logic               evt_valid;
  logic               evt_ready;
  logic [11:0]        evt_sel;
  logic [31:0]        evt_data;
  logic [15:0]        evt_ts;
  logic               evt_ovfl;

  modport slave (
    input  op, tos, rdReg, wrReg, wrReg2, wrEvt, wrEvt2, wrEvtL, evt_ready,
    output par, regs_a, regs_b, evt_valid, evt_sel, evt_data, evt_ts, evt_ovfl
  );

  modport master (
    output op, tos, rdReg, wrReg, wrReg2, wrEvt, wrEvt2, wrEvtL, evt_ready,
    input  par, regs_a, regs_b, evt_valid, evt_sel, evt_data, evt_ts, evt_ovfl
  );
endinterface

// File: rtl/cpu_io_target.sv
// cpu_io_target: CPU I/O responder. Two banks of 32-bit control registers written
// through one-hot selects, a combinational read mux (par) with a FIFO status word on
// select 10, and an event FIFO drained by a valid/ready consumer.
// Optional: CPU_IO_EVT_TIMESTAMP_EN adds a 16-bit free-running cycle counter whose
// value at the push edge travels with each event on evt_ts.
`timescale 1ns/1ps
module cpu_io_target #(
  parameter int NREG      = 8,
  parameter int EVT_DEPTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  cpu_io_target_if.slave bus
);
  localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CW = AW + 1;
`ifdef CPU_IO_EVT_TIMESTAMP_EN
  localparam int EW = 60;
`else
  localparam int EW = 44;
`endif
  localparam logic [AW-1:0] P_ONE  = 1;
  localparam logic [CW-1:0] C_ONE  = 1;
  localparam logic [CW-1:0] C_FULL = CW'(EVT_DEPTH);

  logic [31:0]   r_a [NREG];
  logic [31:0]   r_b [NREG];
  logic [EW-1:0] r_mem [EVT_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_ovfl;

  logic          w_full, w_empty, w_push, w_pop, w_wen, w_ovf, w_clr;
  logic [10:0]   w_sel;
  logic [EW-1:0] w_entry, w_head;
  logic [4:0]    w_cnt5;
  logic [15:0]   w_status, w_par;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.wrEvt | bus.wrEvt2 | bus.wrEvtL;
  assign w_pop   = !w_empty & bus.evt_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign w_wen   = w_push & (!w_full | w_pop);
  assign w_ovf   = w_push & w_full & !w_pop;
  assign w_clr   = bus.rdReg & bus.op[10];
  // loop events carry selects 10:1 only; bit 0 is forced low
  assign w_sel   = bus.wrEvtL ? {bus.op[10:1], 1'b0} : bus.op[10:0];
  assign w_head  = r_mem[r_rp];

`ifdef CPU_IO_EVT_TIMESTAMP_EN
  logic [15:0] r_ts;
  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 16'd1;
  assign w_entry    = {bus.wrEvt2, w_sel, bus.tos, r_ts};
  assign bus.evt_ts = w_empty ? 16'd0 : w_head[15:0];
`else
  assign w_entry    = {bus.wrEvt2, w_sel, bus.tos};
  assign bus.evt_ts = 16'd0;
`endif

  // head fields are gated so an empty FIFO presents zeros instead of stale storage
  assign bus.evt_valid = !w_empty;
  assign bus.evt_sel   = w_empty ? 12'd0 : w_head[EW-1 -: 12];
  assign bus.evt_data  = w_empty ? 32'd0 : w_head[EW-13 -: 32];
  assign bus.evt_ovfl  = r_ovfl;

  // bank writes: every hot select below NREG takes tos
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.wrReg  && bus.op[i]) r_a[i] <= bus.tos;
        if (bus.wrReg2 && bus.op[i]) r_b[i] <= bus.tos;
      end
    end

  for (genvar g = 0; g < NREG; g++) begin : g_pack
    assign bus.regs_a[32*g +: 32] = r_a[g];
    assign bus.regs_b[32*g +: 32] = r_b[g];
  end

  // event storage, no reset needed: contents are only visible while count > 0
  always_ff @(posedge clk)
    if (w_wen) r_mem[r_wp] <= w_entry;

  // pointers, occupancy and sticky overflow (a new overflow beats the clearing read)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovfl  <= 1'b0;
    end else begin
      if (w_wen) r_wp <= r_wp + P_ONE;
      if (w_pop) r_rp <= r_rp + P_ONE;
      if (w_wen && !w_pop)      r_count <= r_count + C_ONE;
      else if (!w_wen && w_pop) r_count <= r_count - C_ONE;
      if (w_ovf)      r_ovfl <= 1'b1;
      else if (w_clr) r_ovfl <= 1'b0;
    end

  // status count field is 5 bits regardless of depth
  always_comb begin
    w_cnt5 = '0;
    for (int k = 0; k < 5 && k < CW; k++) w_cnt5[k] = r_count[k];
  end

  assign w_status = {r_ovfl, w_full, w_empty, 8'b0, w_cnt5};

  // read mux: OR of all hot sources, zero when not reading
  always_comb begin
    w_par = '0;
    if (bus.rdReg) begin
      for (int i = 0; i < NREG; i++)
        if (bus.op[i]) w_par = w_par | r_a[i][15:0];
      if (bus.op[10]) w_par = w_par | w_status;
    end
  end

  assign bus.par = w_par;
endmodule
